// File: rtl/reg_file.sv
// reg_file: eight-entry, 16-bit register file for the multi-cycle CPU datapath.
// It has two combinational read ports and one synchronous write port. R0 always
// reads as zero.
// Optional feature macro: REG_FILE_BYPASS_EN. When it is defined, a write that
// is pending this cycle is forwarded to any read port that addresses the same
// register. When it is undefined (the default), reads return the stored value only.
module reg_file #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reg_write,
    input  logic [ADDR_WIDTH-1:0] reg_dst,
    input  logic [ADDR_WIDTH-1:0] reg_src1,
    input  logic [ADDR_WIDTH-1:0] reg_src2,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];

    // A write is committed only when it is enabled, is not overridden by reset,
    // and does not target R0.
    logic wr_commit;
    assign wr_commit = reg_write && !reset && (reg_dst != '0);

    // Storage update: reset clears every entry and wins over a simultaneous write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_commit) begin
            regs[reg_dst] <= write_data;
        end
    end

`ifdef REG_FILE_BYPASS_EN
    // Read port 1: R0 reads as zero. Otherwise the pending write is forwarded, or
    // the stored value is returned.
    always_comb begin
        read_data1 = regs[reg_src1];
        if (reg_src1 == '0) begin
            read_data1 = '0;
        end else if (wr_commit && (reg_src1 == reg_dst)) begin
            read_data1 = write_data;
        end
    end

    // Read port 2: same selection as port 1, driven from an independent index.
    always_comb begin
        read_data2 = regs[reg_src2];
        if (reg_src2 == '0) begin
            read_data2 = '0;
        end else if (wr_commit && (reg_src2 == reg_dst)) begin
            read_data2 = write_data;
        end
    end
`else
    // Read port 1: returns the stored value. R0 is forced to zero so that it
    // reads 0 even before the first reset.
    always_comb begin
        read_data1 = regs[reg_src1];
        if (reg_src1 == '0) begin
            read_data1 = '0;
        end
    end

    // Read port 2: same selection as port 1, driven from an independent index.
    always_comb begin
        read_data2 = regs[reg_src2];
        if (reg_src2 == '0) begin
            read_data2 = '0;
        end
    end
`endif

endmodule

// File: tb/tb_reg_file.sv
// Testbench for reg_file. It runs directed steps from the test plan, then
// randomized traffic. Every step is checked against an array-based model of
// the register file.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        reg_write = 1'b0;
    logic [2:0]  reg_dst = '0;
    logic [2:0]  reg_src1 = '0;
    logic [2:0]  reg_src2 = '0;
    logic [15:0] write_data = '0;
    logic [15:0] read_data1;
    logic [15:0] read_data2;

    int vectors = 0;
    int errors  = 0;

    logic [15:0] model [8];

`ifdef REG_FILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    reg_file #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .reg_src1   (reg_src1),
        .reg_src2   (reg_src2),
        .write_data (write_data),
        .read_data1 (read_data1),
        .read_data2 (read_data2)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Value that a read port should show in the current cycle, before the edge.
    function automatic logic [15:0] expect_rd(input logic [2:0] src);
        if (src == 3'd0) return 16'h0000;
        if (BYPASS && reg_write && !reset && reg_dst != 3'd0 && src == reg_dst)
            return write_data;
        return model[src];
    endfunction

    // One cycle: drive the inputs, check both read ports mid-cycle, clock the
    // edge, then update the model.
    task automatic step(input logic rst, input logic w, input logic [2:0] dst,
                        input logic [15:0] data, input logic [2:0] s1,
                        input logic [2:0] s2, input string tag);
        logic [15:0] e1, e2;
        @(negedge clk);
        reset = rst; reg_write = w; reg_dst = dst; write_data = data;
        reg_src1 = s1; reg_src2 = s2;
        #1;
        e1 = expect_rd(s1);
        e2 = expect_rd(s2);
        vectors++;
        assert (read_data1 === e1) else begin
            errors++;
            $error("FAIL %s rd1 src=%0d observed=%h expected=%h", tag, s1, read_data1, e1);
        end
        vectors++;
        assert (read_data2 === e2) else begin
            errors++;
            $error("FAIL %s rd2 src=%0d observed=%h expected=%h", tag, s2, read_data2, e2);
        end
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 8; i++) model[i] = 16'h0000;
        end else if (w && dst != 3'd0) begin
            model[dst] = data;
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) model[i] = 16'h0000;

        // R0 reads 0 before the first reset; the reset then clears everything.
        step(1'b1, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd0, "pre_reset_r0");
        step(1'b0, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd0, "reset_r0");
        step(1'b0, 1'b0, 3'd0, 16'h0000, 3'd3, 3'd6, "reset_state");

        // Test plan sequence.
        step(1'b0, 1'b1, 3'd1, 16'hABCD, 3'd1, 3'd0, "wr_r1");
        step(1'b0, 1'b0, 3'd0, 16'h0000, 3'd1, 3'd0, "rd_r1");
        step(1'b0, 1'b1, 3'd2, 16'h1234, 3'd1, 3'd2, "wr_r2");
        step(1'b0, 1'b0, 3'd0, 16'h0000, 3'd1, 3'd2, "rd_r1_r2");
        step(1'b0, 1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd1, "wr_r0");
        step(1'b0, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd1, "rd_r0_r1");
        step(1'b0, 1'b1, 3'd7, 16'h7890, 3'd7, 3'd0, "wr_r7");
        step(1'b0, 1'b0, 3'd0, 16'h0000, 3'd7, 3'd0, "rd_r7");
        step(1'b1, 1'b0, 3'd0, 16'h0000, 3'd1, 3'd7, "reset_pulse");
        step(1'b0, 1'b0, 3'd0, 16'h0000, 3'd1, 3'd7, "rd_after_reset");

        // Reset wins over a simultaneous write, and reset suppresses forwarding.
        step(1'b1, 1'b1, 3'd3, 16'h5555, 3'd3, 3'd3, "reset_vs_write");
        step(1'b0, 1'b0, 3'd0, 16'h0000, 3'd3, 3'd0, "rd_r3");

        // Same-cycle read of the register being written.
        step(1'b0, 1'b1, 3'd4, 16'h0A0A, 3'd4, 3'd0, "wr_r4_old");
        step(1'b0, 1'b1, 3'd4, 16'hBEEF, 3'd4, 3'd4, "wr_r4_same_cycle");
        step(1'b0, 1'b0, 3'd0, 16'h0000, 3'd4, 3'd4, "rd_r4_new");

        // A write with reg_write=0 must not land.
        step(1'b0, 1'b0, 3'd5, 16'hDEAD, 3'd5, 3'd4, "nowrite_r5");
        step(1'b0, 1'b0, 3'd0, 16'h0000, 3'd5, 3'd4, "rd_r5");

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            step((($urandom & 32'h1F) == 32'd0) ? 1'b1 : 1'b0,
                 1'($urandom), 3'($urandom), 16'($urandom),
                 3'($urandom), 3'($urandom), "random");
        end

        // Final sweep over every index on both ports.
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b0, 3'd0, 16'h0000, 3'(k), 3'(7 - k), "sweep");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
